// File: rtl/mem_lock_arbiter.sv
// -----------------------------------------------------------------------------
// mem_lock_arbiter
//
// Round-robin mutex arbiter that shares the global lock memory port among N
// cores. A core keeps req high for as long as it needs exclusive access. The
// arbiter grants one core at a time and keeps that grant until the core drops
// req. While a core owns the port, its address, write data and write enable
// are steered onto the single memory port.
//
// Handshake: req is a level request and gnt is a registered one-hot grant.
// A core may use the port only in cycles where its gnt bit is high. The
// grant is released at the first edge where the owner's req is low. That
// leaves one dead cycle before the next owner is granted. A write enable
// raised without a grant is never forwarded, and it sets err_wr_no_gnt.
//
// Optional feature (macro HOLD_TIMEOUT_EN):
//   The owner is revoked once it has held the port for MAX_HOLD counted hold
//   cycles while another core is waiting. The owner then gets a one-cycle
//   pulse on revoked. It cannot be granted again until it has dropped req
//   for at least one cycle. Without the macro, revoked is tied to 0.
//
// Parameters: N (2..8 cores), AW (address width), DW (data width),
//             MAX_HOLD (hold limit, used only with HOLD_TIMEOUT_EN).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[N]          level request per core
//   addr_in         core i address at [i*AW +: AW]
//   wdata_in        core i write data at [i*DW +: DW]
//   wren_in[N]      per-core write enable
//   gnt[N]          registered one-hot grant
//   stall[N]        req & ~gnt
//   busy            some grant is active
//   owner[3]        index of the current or last owner
//   mem_addr/mem_wdata/mem_wren   memory port, all 0 when idle
//   err_wr_no_gnt   sticky: a write was attempted without a grant
//   revoked[N]      one-cycle revoke pulse (0 without HOLD_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mem_lock_arbiter #(
  parameter int N        = 2,
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] addr_in,
  input  logic [N*DW-1:0] wdata_in,
  input  logic [N-1:0]    wren_in,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    stall,
  output logic            busy,
  output logic [2:0]      owner,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_wren,
  output logic            err_wr_no_gnt,
  output logic [N-1:0]    revoked
);

  if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_bad_param
    $error("mem_lock_arbiter: N must be 2..8 and MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1
`ifdef HOLD_TIMEOUT_EN
    ,
    ST_REVOKE = 2'd2
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [2:0]   owner_q, owner_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic         err_q, err_d;

  logic [N-1:0] elig;
  logic [2:0]   win_idx;
  logic [N-1:0] win_onehot;
  logic         own_req;
  logic [2:0]   ptr_next;

`ifdef HOLD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  revoked_q, revoked_d;
  logic          others_req;

  // A revoked core stays out of arbitration until its req has been low.
  assign elig       = req & ~mask_q;
  assign others_req = |(req & ~gnt_q);
  assign revoked    = revoked_q;
`else
  assign elig       = req;
  assign revoked    = '0;
`endif

  // gnt_q is one-hot on the owner whenever a grant is active, so masking req
  // with it yields the owner's request without a variable-width index.
  assign own_req  = |(req & gnt_q);
  assign ptr_next = (owner_q == 3'(N - 1)) ? 3'd0 : owner_q + 3'd1;

  // Round-robin pick. The lowest eligible index at or above ptr wins, and if
  // there is none, the lowest eligible index overall wins (wrap-around).
  always_comb begin
    logic         hi_found;
    logic [2:0]   hi_idx;
    logic [2:0]   any_idx;
    hi_found   = 1'b0;
    hi_idx     = 3'd0;
    any_idx    = 3'd0;
    win_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_idx = 3'(i);
        if (3'(i) >= ptr_q) begin
          hi_idx   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    win_idx = hi_found ? hi_idx : any_idx;
    for (int i = 0; i < N; i++) begin
      if (3'(i) == win_idx) win_onehot[i] = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    err_d   = err_q | (|(wren_in & ~gnt_q));
`ifdef HOLD_TIMEOUT_EN
    cnt_d     = cnt_q;
    revoked_d = '0;
    mask_d    = mask_q & req;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_HOLD;
          owner_d = win_idx;
          gnt_d   = win_onehot;
`ifdef HOLD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_next;
        end
`ifdef HOLD_TIMEOUT_EN
        else if (cnt_q == CW'(MAX_HOLD) && others_req) begin
          state_d   = ST_REVOKE;
          gnt_d     = '0;
          ptr_d     = ptr_next;
          revoked_d = gnt_q;
          mask_d    = mask_d | gnt_q;
        end else if (cnt_q != CW'(MAX_HOLD)) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef HOLD_TIMEOUT_EN
      ST_REVOKE: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= '0;
      revoked_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
`ifdef HOLD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      revoked_q <= revoked_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign stall         = req & ~gnt_q;
  assign busy          = |gnt_q;
  assign owner         = owner_q;
  assign err_wr_no_gnt = err_q;

  // The port follows only the granted core. Steering by gnt_q is the same as
  // steering by owner while busy, and it leaves every output at 0 when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        mem_addr  = addr_in[i*AW +: AW];
        mem_wdata = wdata_in[i*DW +: DW];
        mem_wren  = wren_in[i];
      end
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_lock_arbiter
//
// Testbench for mem_lock_arbiter, default build (N=2, AW=6, DW=32).
// Each cycle the bench drives new inputs 1 ns after the rising edge. A small
// reference model predicts the outputs after the next edge and pushes the
// prediction onto exp_q. The entry is popped and compared 1 ns after that
// edge.
// -----------------------------------------------------------------------------
module tb_mem_lock_arbiter;

  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 32;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          busy;
    logic [2:0]    owner;
    logic          err;
    logic [N-1:0]  stall;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wren;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [N-1:0]    wren_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    stall;
  logic            busy;
  logic [2:0]      owner;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_wren;
  logic            err_wr_no_gnt;
  logic [N-1:0]    revoked;

  // Clock and reset: reset is driven through the cycle task.
  always #5 clk = ~clk;

  mem_lock_arbiter #(.N(N), .AW(AW), .DW(DW), .MAX_HOLD(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .wren_in       (wren_in),
    .gnt           (gnt),
    .stall         (stall),
    .busy          (busy),
    .owner         (owner),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wren      (mem_wren),
    .err_wr_no_gnt (err_wr_no_gnt),
    .revoked       (revoked)
  );

  // Scoreboard state.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic m_hold = 1'b0;
  int   m_owner = 0;
  int   m_ptr = 0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard: expected queue empty at t=%0t", $time);
    end else begin
      e = exp_t'(exp_q.pop_front());
      check("gnt",       64'(gnt),           64'(e.gnt));
      check("busy",      64'(busy),          64'(e.busy));
      check("owner",     64'(owner),         64'(e.owner));
      check("err",       64'(err_wr_no_gnt), 64'(e.err));
      check("stall",     64'(stall),         64'(e.stall));
      check("mem_addr",  64'(mem_addr),      64'(e.addr));
      check("mem_wdata", 64'(mem_wdata),     64'(e.wdata));
      check("mem_wren",  64'(mem_wren),      64'(e.wren));
`ifndef HOLD_TIMEOUT_EN
      check("revoked",   64'(revoked),       64'd0);
`endif
    end
  endtask

  // Driver: apply one cycle of stimulus, predict the result and check it.
  task automatic cycle(input logic do_rst, input logic [N-1:0] r, input logic [N-1:0] w);
    exp_t         e;
    logic [N-1:0] gcur;
    rst      = do_rst;
    req      = r;
    wren_in  = w;
    addr_in  = (N*AW)'($urandom());
    wdata_in = {$urandom(), $urandom()};

    gcur = m_hold ? N'(1 << m_owner) : '0;
    if (do_rst) begin
      m_hold  = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
    end else begin
      if ((w & ~gcur) != '0) m_err = 1'b1;
      if (!m_hold) begin
        if (r != '0) begin
          m_hold  = 1'b1;
          m_owner = r[m_ptr] ? m_ptr : 1 - m_ptr;
        end
      end else if (!r[m_owner]) begin
        m_hold = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end

    e.gnt   = m_hold ? N'(1 << m_owner) : '0;
    e.busy  = m_hold;
    e.owner = 3'(m_owner);
    e.err   = m_err;
    e.stall = r & ~e.gnt;
    e.addr  = m_hold ? addr_in[m_owner*AW +: AW] : '0;
    e.wdata = m_hold ? wdata_in[m_owner*DW +: DW] : '0;
    e.wren  = m_hold ? w[m_owner] : 1'b0;
    exp_q.push_back(EW'(e));

    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    logic [N-1:0] r_rand;
    logic [N-1:0] w_rand;
    rst      = 1'b1;
    req      = '0;
    wren_in  = '0;
    addr_in  = '0;
    wdata_in = '0;
    @(posedge clk);
    #1;

    // Reset state.
    cycle(1'b1, 2'b00, 2'b00);
    cycle(1'b1, 2'b00, 2'b00);

    // Single requester: one-cycle grant latency and the memory mux follows core 0.
    cycle(1'b0, 2'b00, 2'b00);
    cycle(1'b0, 2'b01, 2'b00);
    repeat (3) cycle(1'b0, 2'b01, 2'b01);
    cycle(1'b0, 2'b00, 2'b00);
    cycle(1'b0, 2'b00, 2'b00);

    // Both request from reset. Core 0 drops for one cycle, then core 1 owns the port.
    cycle(1'b1, 2'b00, 2'b00);
    repeat (3) cycle(1'b0, 2'b11, 2'b00);
    cycle(1'b0, 2'b10, 2'b00);
    repeat (3) cycle(1'b0, 2'b11, 2'b00);

    // Continuous contention: each owner drops after 4 held cycles, so grants alternate.
    for (int h = 0; h < 4; h++) begin
      repeat (4) cycle(1'b0, 2'b11, 2'b00);
      cycle(1'b0, (m_owner == 0) ? 2'b10 : 2'b01, 2'b00);
    end

    // A write without a grant sets the sticky error, which only reset clears.
    cycle(1'b1, 2'b00, 2'b00);
    cycle(1'b0, 2'b01, 2'b00);
    cycle(1'b0, 2'b01, 2'b10);
    repeat (3) cycle(1'b0, 2'b01, 2'b01);
    cycle(1'b0, 2'b00, 2'b00);
    cycle(1'b0, 2'b00, 2'b00);
    cycle(1'b1, 2'b00, 2'b00);

    // Reset while core 1 holds the port, then both request: core 0 wins.
    cycle(1'b0, 2'b10, 2'b00);
    repeat (2) cycle(1'b0, 2'b10, 2'b00);
    cycle(1'b1, 2'b10, 2'b00);
    repeat (2) cycle(1'b0, 2'b11, 2'b00);

    // Random traffic with sticky requests and occasional writes.
    cycle(1'b1, 2'b00, 2'b00);
    r_rand = '0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) r_rand = N'($urandom_range(0, 3));
      w_rand = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 3)) : '0;
      cycle(($urandom_range(0, 99) == 0), r_rand, w_rand);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
